// File: rtl/ixu_bundle_encoder_if.sv
// Scheduler-to-encoder request channel and encoder-to-instruction-buffer bundle channel.
// master drives requests and consumes bundles; slave is the encoder side.
// Carries valid/ready pairs on both sides, so either end may stall the other.
interface ixu_bundle_encoder_if #(
    parameter int SLOTS = 4
);
    localparam int CW = $clog2(SLOTS + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_op;
    logic                  in_is_imm;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [11:0]           in_imm;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [32*SLOTS-1:0]   out_bundle;
    logic [CW-1:0]         out_count;
    logic                  err_illegal;

    modport master (
        output in_valid, in_op, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, flush, out_ready,
        input  in_ready, out_valid, out_bundle, out_count, err_illegal
    );

    modport slave (
        input  in_valid, in_op, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, flush, out_ready,
        output in_ready, out_valid, out_bundle, out_count, err_illegal
    );
endinterface

// File: rtl/ixu_bundle_encoder.sv
// Encodes IXU ALU micro-ops into RV32I words and packs SLOTS of them per VLIW bundle (IXU_ENC_TIMEOUT_EN adds idle auto-close).
// Latency: a word is visible one cycle after the accept that closes its bundle; one bubble cycle per bundle.
// Backpressure: a closed bundle holds stable with in_ready low until out_ready is seen.
module ixu_bundle_encoder #(
    parameter int SLOTS   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ixu_bundle_encoder_if.slave  bus
);
    localparam int CW = $clog2(SLOTS + 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [32*SLOTS-1:0] bundle_q;
    logic [CW-1:0]       count_q;
    logic                err_q;

    logic                in_ready_c;
    logic                out_valid_c;
    logic                accept;
    logic                drain;
    logic                close_req;
    logic                tmo_fire;

    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [11:0]         imm12;
    logic                enc_illegal;
    logic [31:0]         enc_word;

    assign accept = bus.in_valid && in_ready_c;
    assign drain  = out_valid_c && bus.out_ready;

    // Word encoder: purely combinational, written into the slot on accept.
    always_comb begin
        funct3      = 3'd0;
        funct7      = 7'h00;
        imm12       = bus.in_imm;
        enc_illegal = (bus.in_op > 4'd9) || ((bus.in_op == 4'd1) && bus.in_is_imm);
        case (bus.in_op)
            4'd0, 4'd1: funct3 = 3'd0;
            4'd2:       funct3 = 3'd4;
            4'd3:       funct3 = 3'd6;
            4'd4:       funct3 = 3'd7;
            4'd5:       funct3 = 3'd1;
            4'd6, 4'd7: funct3 = 3'd5;
            4'd8:       funct3 = 3'd2;
            4'd9:       funct3 = 3'd3;
            default:    funct3 = 3'd0;
        endcase
        if ((bus.in_op == 4'd1) || (bus.in_op == 4'd7)) begin
            funct7 = 7'h20;
        end
        // Shift immediates carry only shamt; the upper field selects logical vs arithmetic.
        if ((bus.in_op == 4'd5) || (bus.in_op == 4'd6)) begin
            imm12 = {7'h00, bus.in_imm[4:0]};
        end else if (bus.in_op == 4'd7) begin
            imm12 = {7'h20, bus.in_imm[4:0]};
        end
        if (enc_illegal) begin
            enc_word = 32'h0000_0000;
        end else if (bus.in_is_imm) begin
            enc_word = {imm12, bus.in_rs1, funct3, bus.in_rd, 7'b0010011};
        end else begin
            enc_word = {funct7, bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, 7'b0110011};
        end
    end

    // A flush only closes a bundle that will hold at least one word.
    assign close_req = (accept && (count_q == CW'(SLOTS - 1)))
                     || (bus.flush && (accept || (count_q != '0)))
                     || tmo_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (close_req) state_d = FULL;
            FULL:    if (bus.out_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            FILL:    in_ready_c  = 1'b1;
            FULL:    out_valid_c = 1'b1;
            default: in_ready_c  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept && enc_illegal;
            if (drain) begin
                bundle_q <= '0;
                count_q  <= '0;
            end else if (accept) begin
                for (int k = 0; k < SLOTS; k++) begin
                    if (count_q == CW'(k)) begin
                        bundle_q[32*k +: 32] <= enc_word;
                    end
                end
                count_q <= count_q + CW'(1);
            end
        end
    end

`ifdef IXU_ENC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q;
    logic          tmo_tick;

    assign tmo_tick = (state_q == FILL) && (count_q != '0) && !accept;
    assign tmo_fire = tmo_tick && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || accept || (state_d != FILL)) begin
            tmo_q <= '0;
        end else if (tmo_tick) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    assign tmo_fire = 1'b0 && (TIMEOUT > 0);
`endif

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_bundle  = bundle_q;
    assign bus.out_count   = count_q;
    assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_ixu_bundle_encoder.sv
// Bench for ixu_bundle_encoder: vector table of hand-encoded words plus corner-case sequences.
// A reference model of the fill/full behaviour and a word queue predict every output each cycle.
// Honours IXU_ENC_TIMEOUT_EN the same way the design does.
module tb_ixu_bundle_encoder;
    localparam int SLOTS = 4;
    localparam int TMO   = 8;
    localparam int W     = 32 * SLOTS;

    typedef struct {
        logic [3:0]  op;
        bit          is_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [31:0] word;
        bit          ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ixu_bundle_encoder_if #(.SLOTS(SLOTS)) bus ();

    ixu_bundle_encoder #(.SLOTS(SLOTS), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          m_full  = 1'b0;
    int          m_tmo   = 0;
    bit          m_acc   = 1'b0;
    bit          err_exp = 1'b0;
    logic [31:0] cur_word = '0;
    bit          cur_ill  = 1'b0;
    vec_t        tab[23];

    function automatic vec_t mk(input logic [3:0] op, input bit is_imm, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                                input logic [31:0] word, input bit ill);
        vec_t v;
        v.op = op; v.is_imm = is_imm; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.word = word; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance the model across the coming edge.
    task automatic cycle();
        logic [W-1:0] eb;
        bit           close;
        @(negedge clk);
        eb = '0;
        foreach (exp_q[k]) eb[32*k +: 32] = exp_q[k];
        check("out_valid",   W'(bus.out_valid),   W'(m_full));
        check("in_ready",    W'(bus.in_ready),    W'(!m_full));
        check("out_count",   W'(bus.out_count),   W'(exp_q.size()));
        check("out_bundle",  bus.out_bundle,      eb);
        check("err_illegal", W'(bus.err_illegal), W'(err_exp));
        m_acc   = 1'b0;
        err_exp = 1'b0;
        if (rst) begin
            m_full = 1'b0;
            m_tmo  = 0;
            exp_q.delete();
        end else if (m_full) begin
            if (bus.out_ready) begin
                m_full = 1'b0;
                exp_q.delete();
            end
        end else begin
            close = 1'b0;
            if (bus.in_valid) begin
                m_acc = 1'b1;
                exp_q.push_back(cur_word);
                err_exp = cur_ill;
                m_tmo   = 0;
                close   = (exp_q.size() == SLOTS) || bus.flush;
            end else begin
                close = bus.flush && (exp_q.size() > 0);
`ifdef IXU_ENC_TIMEOUT_EN
                if (exp_q.size() > 0) begin
                    m_tmo++;
                    if (m_tmo == TMO) close = 1'b1;
                end
`endif
            end
            if (close) begin
                m_full = 1'b1;
                m_tmo  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input bit fl, input int ordy);
        int tries = 0;
        do begin
            bus.in_valid  = 1'b1;
            bus.in_op     = v.op;
            bus.in_is_imm = v.is_imm;
            bus.in_rd     = v.rd;
            bus.in_rs1    = v.rs1;
            bus.in_rs2    = v.rs2;
            bus.in_imm    = v.imm;
            bus.flush     = fl;
            bus.out_ready = (ordy < 0) ? ($urandom_range(0, 3) != 0) : (ordy != 0);
            cur_word      = v.word;
            cur_ill       = v.ill;
            cycle();
            tries++;
        end while (!m_acc && tries < 50);
        if (!m_acc) begin
            checks++;
            errors++;
            $display("FAIL send_stall act=not_accepted exp=accepted t=%0t", $time);
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy, input bit fl);
        bus.in_valid  = 1'b0;
        bus.flush     = fl;
        bus.out_ready = ordy;
        for (int i = 0; i < n; i++) cycle();
        bus.flush = 1'b0;
    endtask

    initial begin
        int n;
        tab[0]  = mk(4'd0,  0, 5'd3,  5'd1,  5'd2,  12'h000, 32'h002081B3, 0);
        tab[1]  = mk(4'd1,  0, 5'd4,  5'd5,  5'd6,  12'h000, 32'h40628233, 0);
        tab[2]  = mk(4'd2,  0, 5'd7,  5'd8,  5'd9,  12'h000, 32'h009443B3, 0);
        tab[3]  = mk(4'd3,  0, 5'd10, 5'd11, 5'd12, 12'h000, 32'h00C5E533, 0);
        tab[4]  = mk(4'd4,  0, 5'd13, 5'd14, 5'd15, 12'h000, 32'h00F776B3, 0);
        tab[5]  = mk(4'd5,  0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h003110B3, 0);
        tab[6]  = mk(4'd6,  0, 5'd16, 5'd17, 5'd18, 12'h000, 32'h0128D833, 0);
        tab[7]  = mk(4'd7,  0, 5'd31, 5'd30, 5'd29, 12'h000, 32'h41DF5FB3, 0);
        tab[8]  = mk(4'd8,  0, 5'd2,  5'd3,  5'd4,  12'h000, 32'h0041A133, 0);
        tab[9]  = mk(4'd9,  0, 5'd5,  5'd6,  5'd7,  12'h000, 32'h007332B3, 0);
        tab[10] = mk(4'd0,  1, 5'd5,  5'd0,  5'd31, 12'hFFF, 32'hFFF00293, 0);
        tab[11] = mk(4'd7,  1, 5'd1,  5'd1,  5'd31, 12'h003, 32'h4030D093, 0);
        tab[12] = mk(4'd5,  1, 5'd6,  5'd7,  5'd31, 12'hFE5, 32'h00539313, 0);
        tab[13] = mk(4'd6,  1, 5'd8,  5'd9,  5'd31, 12'h7FF, 32'h01F4D413, 0);
        tab[14] = mk(4'd2,  1, 5'd10, 5'd11, 5'd31, 12'h800, 32'h8005C513, 0);
        tab[15] = mk(4'd9,  1, 5'd12, 5'd13, 5'd31, 12'h123, 32'h1236B613, 0);
        tab[16] = mk(4'd4,  1, 5'd1,  5'd2,  5'd31, 12'h0F0, 32'h0F017093, 0);
        tab[17] = mk(4'd7,  1, 5'd3,  5'd4,  5'd31, 12'hFE2, 32'h40225193, 0);
        tab[18] = mk(4'd8,  1, 5'd2,  5'd3,  5'd31, 12'hF00, 32'hF001A113, 0);
        tab[19] = mk(4'd3,  1, 5'd4,  5'd4,  5'd31, 12'h555, 32'h55526213, 0);
        tab[20] = mk(4'd1,  1, 5'd5,  5'd6,  5'd7,  12'h123, 32'h00000000, 1);
        tab[21] = mk(4'd12, 0, 5'd7,  5'd8,  5'd9,  12'h000, 32'h00000000, 1);
        tab[22] = mk(4'd15, 1, 5'd9,  5'd9,  5'd9,  12'hABC, 32'h00000000, 1);

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_is_imm = 1'b0; bus.in_rd = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;

        rst = 1'b1;
        idle(2, 1, 0);
        rst = 1'b0;
        idle(2, 1, 0);

        // Whole table streamed with random consumer backpressure, then the partial tail flushed.
        foreach (tab[i]) send(tab[i], 0, -1);
        idle(1, 1, 1);
        idle(3, 1, 0);

        // Single add closed by a following flush.
        send(tab[0], 0, 1);
        idle(1, 1, 1);
        idle(2, 1, 0);

        // Back-to-back immediates fill a bundle with no gaps.
        send(tab[10], 0, 1); send(tab[11], 0, 1); send(tab[12], 0, 1); send(tab[13], 0, 1);
        idle(2, 1, 0);

        // Held bundle under backpressure, with a flush that must be ignored while full.
        send(tab[1], 0, 0); send(tab[2], 0, 0); send(tab[3], 0, 0); send(tab[4], 0, 0);
        idle(2, 0, 0);
        idle(3, 0, 1);
        idle(3, 1, 0);

        // Illegal requests become counted NOP slots.
        send(tab[20], 0, 1); send(tab[21], 0, 1);
        idle(1, 1, 1);
        idle(2, 1, 0);

        // Flush on an empty bundle produces nothing; flush with an accept closes at one word.
        idle(3, 1, 1);
        send(tab[5], 1, 1);
        idle(2, 1, 0);

        // Reset in the middle of a fill discards the partial bundle.
        send(tab[6], 0, 1); send(tab[7], 0, 1);
        rst = 1'b1;
        idle(1, 1, 0);
        rst = 1'b0;
        idle(2, 1, 0);

        // One accept followed by idle cycles.
        send(tab[8], 0, 0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            idle(1, 0, 0);
            n++;
        end
`ifdef IXU_ENC_TIMEOUT_EN
        check("timeout_cycles", W'(n), W'(TMO));
        idle(2, 1, 0);
`else
        check("no_timeout_valid", W'(bus.out_valid), W'(0));
        idle(1, 1, 1);
        idle(2, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ixu_bundle_encoder.md
# ixu_bundle_encoder

Encodes integer-execution-unit (IXU) micro-op requests into 32-bit RV32I ALU instruction words and packs them into fixed-width VLIW bundles. It sits between the scheduler and the instruction buffer; the words it produces are exactly what the IXU decode stage accepts. Unfilled slots are padded with the IXU NOP word `32'h00000000`. Illegal requests are replaced by NOPs and flagged.

## Interface
Parameters:
- `SLOTS`, 4: instruction slots per bundle (≥2).
- `TIMEOUT`, 8: idle cycles before a partial bundle is auto-closed (used only with the macro).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: encoder can accept a request.
- `in_op` in 4: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
- `in_is_imm` in 1: encode I-type (opcode 0010011) instead of R-type (0110011).
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices; `in_rs2` is ignored for I-type.
- `in_imm` in 12: immediate.
- `flush` in 1: close the current partial bundle.
- `out_valid` out 1: bundle valid.
- `out_ready` in 1: consumer accepts the bundle.
- `out_bundle` out 32*SLOTS: slot 0 in bits [31:0], slot k in bits [32k+31:32k].
- `out_count` out $clog2(SLOTS+1): number of non-pad slots.
- `err_illegal` out 1: one-cycle pulse when an illegal request is accepted.

## Operation
- funct3 by op:
  - add/sub: 0
  - sll: 1
  - slt: 2
  - sltu: 3
  - xor: 4
  - srl/sra: 5
  - or: 6
  - and: 7
- R-type word: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - funct7 = 7'h20 for sub and sra; 7'h00 otherwise.
- I-type word: {imm12, rs1, funct3, rd, 7'b0010011}.
  - slli and srli: imm12 = {7'h00, in_imm[4:0]}.
  - srai: imm12 = {7'h20, in_imm[4:0]}.
  - All other I-type ops: in_imm verbatim.
- Illegal requests: op ≥ 10, or op 1 with in_is_imm=1.
  - Slot is written with `32'h0` and counts toward `out_count`.
  - `err_illegal` pulses for one cycle.
- FSM states:
  - FILL: `in_ready`=1, `out_valid`=0.
  - FULL: `in_ready`=0, `out_valid`=1, outputs held stable.
- An accepted request writes slot `idx`, then `idx` increments.
- FILL → FULL when any of these occur:
  - the last slot (idx = SLOTS-1) is accepted;
  - `flush` is asserted with idx > 0 or with a same-cycle accept;
  - the timeout fires (macro builds only).
- FULL → FILL on `out_valid && out_ready`.
  - On that transition: all slots clear to `32'h0`, idx=0, `out_count`=0.
- Boundary cases:
  - `flush` with an empty bundle and no accept is ignored; no empty bundle is ever emitted.
  - `flush` together with an accept: the word is included, then the bundle closes.
  - `flush` in FULL is ignored.
  - `rst` mid-bundle discards contents.
- Reset values: state FILL, idx 0, `in_ready` 1, `out_valid` 0, `out_bundle` 0, `out_count` 0, `err_illegal` 0.

## Timing
- Registered outputs.
- Encoding latency: a word accepted in cycle N appears in `out_bundle` when `out_valid` rises.
  - Earliest rise is cycle N+1, when the accept fills the last slot or coincides with flush.
- Throughput: one request per cycle in FILL.
  - One bubble cycle per bundle: the FULL cycle, when `in_ready`=0.
  - With `out_ready` tied high: SLOTS words every SLOTS+1 cycles.
- `out_bundle` and `out_count` hold while `out_valid && !out_ready`.
- `err_illegal` is asserted in cycle N+1 for an illegal accept in cycle N.

## Configuration
- Macro: `IXU_ENC_TIMEOUT_EN`.
- Defined:
  - A counter increments each FILL cycle with idx > 0 and no accept.
  - It resets on any accept or on leaving FILL.
  - On reaching TIMEOUT it forces FILL → FULL, identical to flush.
- Undefined:
  - No counter; `TIMEOUT` is unused.
  - Partial bundles close only on `flush`.

## Test plan
- Add, R-type: add rd=3 rs1=1 rs2=2, then flush → out_bundle[31:0]=0x002081B3, out_count=1, slots 1–3 = 0.
- Full bundle with immediates, out_ready=1: addi x5,x0,-1 (imm 0xFFF) → 0xFFF00293. srai x1,x1,3 → 0x4030D093. Four back-to-back accepts → out_valid in cycle 4, out_count=4, in_ready=0 for exactly one cycle.
- Backpressure: out_ready=0 for 5 cycles with a full bundle → out_bundle stable, in_ready=0. out_ready=1 → FILL next cycle, bundle cleared.
- Illegal requests: op=1 with in_is_imm=1, and op=12 → each slot = 0x00000000, err_illegal pulses once per request, both counted in out_count.
- Flush boundaries: flush on an empty bundle → no out_valid. flush with an accept → out_count=1. rst mid-fill (2 slots) → out_count=0, out_bundle=0.
- With `IXU_ENC_TIMEOUT_EN` and TIMEOUT=8: one accept then idle → out_valid asserts exactly 8 idle cycles later, out_count=1. Without the macro → no out_valid after 20 idle cycles.
